// File: rtl/pingpong_frame_buffer_pkg.sv
// Shared constants, event-pulse struct and helpers for the ping-pong frame buffer.
package pingpong_frame_buffer_pkg;

    // SKUT frame geometry and DAC idle code used as parameter defaults
    localparam int         PFB_DATA_W    = 8;
    localparam int         PFB_ADDR_W    = 7;
    localparam int         PFB_DEPTH     = 128;
    localparam logic [7:0] PFB_IDLE_FILL = 8'h80;

    // One-cycle event pulses, registered together
    typedef struct packed {
        logic wr_drop;
        logic underrun;
        logic overrun;
    } pfb_evt_t;

    // Saturating add of up to two events onto an 8-bit error counter
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/pingpong_frame_buffer_if.sv
// Write-side, read-side and status signals of the ping-pong frame buffer.
interface pingpong_frame_buffer_if
    import pingpong_frame_buffer_pkg::*;
#(
    parameter int DATA_W = PFB_DATA_W,
    parameter int ADDR_W = PFB_ADDR_W
);
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              wr_done;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              rd_swap;
    logic [DATA_W-1:0] rd_data;
    logic              rd_bank;
    logic              frame_ready;
    logic              wr_drop;
    logic              underrun;
    logic              overrun;
    logic [15:0]       frame_cnt;
    logic [7:0]        err_cnt;

    modport master (
        output wr_data, wr_addr, wr_en, wr_done, rd_addr, rd_en, rd_swap,
        input  rd_data, rd_bank, frame_ready, wr_drop, underrun, overrun, frame_cnt, err_cnt
    );

    modport slave (
        input  wr_data, wr_addr, wr_en, wr_done, rd_addr, rd_en, rd_swap,
        output rd_data, rd_bank, frame_ready, wr_drop, underrun, overrun, frame_cnt, err_cnt
    );
endinterface

// File: rtl/pingpong_frame_buffer_pp_bank_ram.sv
// Simple dual-port bank RAM: one write port, one registered read port.
module pp_bank_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write and registered read; output holds while re is low
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/pingpong_frame_buffer.sv
// Double-bank frame store: writer fills one bank while the reader plays the other;
// banks trade places on rd_swap once the writer has declared a complete frame.
module pingpong_frame_buffer
    import pingpong_frame_buffer_pkg::*;
#(
    parameter int              DATA_W    = PFB_DATA_W,
    parameter int              ADDR_W    = PFB_ADDR_W,
    parameter int              DEPTH     = PFB_DEPTH,
    parameter logic [DATA_W-1:0] IDLE_FILL = DATA_W'(PFB_IDLE_FILL),
    parameter bit              REPEAT_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    pingpong_frame_buffer_if.slave  bus
);
    // DEPTH may equal 2**ADDR_W, so compare in one extra bit
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic rd_bank_q, rd_bank_d;
    logic frame_ready_q, frame_ready_d;
    logic have_frame_q, have_frame_d;
    logic fill_mode_q, fill_mode_d;
    logic rd_sel_q, rd_sel_d;
    logic rd_fill_q, rd_fill_d;
    pfb_evt_t evt_q, evt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic swap_ok, wr_fire;
    logic wr_in_range, rd_in_range;
    logic [1:0] bank_we;
    logic [1:0][DATA_W-1:0] bank_dout;

    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_L;

    // Next-state for bank control, event pulses, counters and read-path selects
    always_comb begin
        // wr_done in the swap cycle counts as a ready frame (done applies first)
        swap_ok        = bus.rd_swap && (frame_ready_q || bus.wr_done);
        wr_fire        = bus.wr_en && !frame_ready_q && wr_in_range;
        evt_d.wr_drop  = bus.wr_en && frame_ready_q;
        evt_d.underrun = bus.rd_swap && !swap_ok;
        evt_d.overrun  = bus.wr_done && frame_ready_q;

        rd_bank_d     = rd_bank_q ^ swap_ok;
        have_frame_d  = have_frame_q | swap_ok;
        frame_ready_d = frame_ready_q;
        if (swap_ok)          frame_ready_d = 1'b0;
        else if (bus.wr_done) frame_ready_d = 1'b1;
        fill_mode_d = fill_mode_q;
        if (swap_ok)                              fill_mode_d = 1'b0;
        else if (evt_d.underrun && !REPEAT_EN)    fill_mode_d = 1'b1;

        frame_cnt_d = frame_cnt_q + 16'(swap_ok);
        err_cnt_d   = sat_add8(err_cnt_q, {1'b0, evt_d.underrun} + {1'b0, evt_d.overrun});

        // Read selects follow the post-swap state so a swap+read cycle sees the new bank
        rd_sel_d  = rd_sel_q;
        rd_fill_d = rd_fill_q;
        if (bus.rd_en) begin
            rd_sel_d  = rd_bank_d;
            rd_fill_d = !have_frame_d || fill_mode_d || !rd_in_range;
        end

        // Writer always targets the bank the reader is not using
        bank_we[0] = wr_fire && rd_bank_q;
        bank_we[1] = wr_fire && !rd_bank_q;
    end

    // Control, counter and read-select registers with asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_bank_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            have_frame_q  <= 1'b0;
            fill_mode_q   <= 1'b0;
            rd_sel_q      <= 1'b0;
            rd_fill_q     <= 1'b1;
            evt_q         <= '0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
        end else begin
            rd_bank_q     <= rd_bank_d;
            frame_ready_q <= frame_ready_d;
            have_frame_q  <= have_frame_d;
            fill_mode_q   <= fill_mode_d;
            rd_sel_q      <= rd_sel_d;
            rd_fill_q     <= rd_fill_d;
            evt_q         <= evt_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pp_bank_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (bus.wr_addr),
            .wdata (bus.wr_data),
            .re    (bus.rd_en),
            .raddr (bus.rd_addr),
            .rdata (bank_dout[b])
        );
    end

    // Output mux sits purely on registers (RAM read regs and the read selects)
    assign bus.rd_data     = rd_fill_q ? IDLE_FILL : bank_dout[rd_sel_q];
    assign bus.rd_bank     = rd_bank_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.wr_drop     = evt_q.wr_drop;
    assign bus.underrun    = evt_q.underrun;
    assign bus.overrun     = evt_q.overrun;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Scoreboard bench: dut_a (REPEAT_EN=1, DEPTH=128) and dut_b (REPEAT_EN=0, DEPTH=100)
// share the same stimulus; read data is checked by a monitor against queued expectations.
module tb_pingpong_frame_buffer;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rd_en_seen = 1'b0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    pingpong_frame_buffer_if #(.DATA_W(8), .ADDR_W(7)) ia ();
    pingpong_frame_buffer_if #(.DATA_W(8), .ADDR_W(7)) ib ();

    pingpong_frame_buffer #(.DEPTH(128), .REPEAT_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    pingpong_frame_buffer #(.DEPTH(100), .REPEAT_EN(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

    assign ib.wr_data = ia.wr_data;
    assign ib.wr_addr = ia.wr_addr;
    assign ib.wr_en   = ia.wr_en;
    assign ib.wr_done = ia.wr_done;
    assign ib.rd_addr = ia.rd_addr;
    assign ib.rd_en   = ia.rd_en;
    assign ib.rd_swap = ia.rd_swap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Status common to both DUTs
    task automatic chk_stat(input string tag, input logic bank, input logic rdy,
                            input logic [15:0] fc, input logic [7:0] ec);
        check({tag, " a.rd_bank"}, ia.rd_bank, bank);
        check({tag, " b.rd_bank"}, ib.rd_bank, bank);
        check({tag, " a.frame_ready"}, ia.frame_ready, rdy);
        check({tag, " b.frame_ready"}, ib.frame_ready, rdy);
        check({tag, " a.frame_cnt"}, ia.frame_cnt, fc);
        check({tag, " b.frame_cnt"}, ib.frame_cnt, fc);
        check({tag, " a.err_cnt"}, ia.err_cnt, ec);
        check({tag, " b.err_cnt"}, ib.err_cnt, ec);
    endtask

    task automatic chk_pulse(input string tag, input logic drop, input logic ur, input logic ovr);
        check({tag, " a.wr_drop"}, ia.wr_drop, drop);
        check({tag, " b.wr_drop"}, ib.wr_drop, drop);
        check({tag, " a.underrun"}, ia.underrun, ur);
        check({tag, " b.underrun"}, ib.underrun, ur);
        check({tag, " a.overrun"}, ia.overrun, ovr);
        check({tag, " b.overrun"}, ib.overrun, ovr);
    endtask

    // One clock with the current strobes, then strobes return low
    task automatic tick();
        @(negedge clk);
        ia.wr_en = 1'b0; ia.wr_done = 1'b0; ia.rd_en = 1'b0; ia.rd_swap = 1'b0;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        ia.wr_en = 1'b1; ia.wr_addr = a; ia.wr_data = d; tick();
    endtask

    task automatic done();
        ia.wr_done = 1'b1; tick();
    endtask

    task automatic swap();
        ia.rd_swap = 1'b1; tick();
    endtask

    task automatic rd(input logic [6:0] a, input logic [7:0] ea, input logic [7:0] eb);
        ia.rd_en = 1'b1; ia.rd_addr = a;
        qa.push_back(ea); qb.push_back(eb);
        tick();
    endtask

    // Monitor: rd_data is due one cycle after an accepted rd_en
    always @(posedge clk) rd_en_seen <= ia.rd_en;
    always @(negedge clk) begin : mon
        logic [7:0] ea, eb;
        if (rd_en_seen) begin
            if (qa.size() == 0 || qb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL scoreboard: read with no expectation queued");
            end else begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                check("a.rd_data", ia.rd_data, ea);
                check("b.rd_data", ib.rd_data, eb);
            end
        end
    end

    initial begin
        reset = 1'b0;
        ia.wr_data = '0; ia.wr_addr = '0; ia.wr_en = 1'b0; ia.wr_done = 1'b0;
        ia.rd_addr = '0; ia.rd_en = 1'b0; ia.rd_swap = 1'b0;
        repeat (2) @(negedge clk);
        check("reset a.rd_data", ia.rd_data, 8'h80);
        check("reset b.rd_data", ib.rd_data, 8'h80);
        chk_stat("reset", 1'b0, 1'b0, 16'd0, 8'd0);
        chk_pulse("reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();

        // No frame yet: idle code only
        rd(7'd5, 8'h80, 8'h80);
        rd(7'd127, 8'h80, 8'h80);

        // First frame into bank 1, data = address
        for (int i = 0; i < 128; i++) wr(7'(i), 8'(i));
        done();
        chk_stat("after done", 1'b0, 1'b1, 16'd0, 8'd0);
        swap();
        chk_stat("first swap", 1'b1, 1'b0, 16'd1, 8'd0);
        rd(7'd5, 8'd5, 8'd5);
        rd(7'd127, 8'd127, 8'h80);

        // Underrun: A repeats the frame, B falls back to idle fill
        swap();
        chk_pulse("underrun", 1'b0, 1'b1, 1'b0);
        chk_stat("underrun", 1'b1, 1'b0, 16'd1, 8'd1);
        rd(7'd5, 8'd5, 8'h80);
        chk_pulse("underrun gone", 1'b0, 1'b0, 1'b0);

        // Second frame into bank 0, data = address + 0x10
        for (int i = 0; i < 128; i++) wr(7'(i), 8'(i + 16));
        done();
        check("frame2 ready", ia.frame_ready, 1'b1);

        // Locked bank: write dropped, second done is an overrun
        wr(7'd0, 8'hAA);
        chk_pulse("wr_drop", 1'b1, 1'b0, 1'b0);
        done();
        chk_pulse("overrun", 1'b0, 1'b0, 1'b1);
        chk_stat("overrun", 1'b1, 1'b1, 16'd1, 8'd2);
        swap();
        chk_stat("second swap", 1'b0, 1'b0, 16'd2, 8'd2);
        rd(7'd0, 8'h10, 8'h10);
        rd(7'd5, 8'h15, 8'h15);

        // Same-cycle done and swap
        wr(7'd3, 8'h33);
        ia.wr_done = 1'b1; swap();
        chk_pulse("done+swap", 1'b0, 1'b0, 1'b0);
        chk_stat("done+swap", 1'b1, 1'b0, 16'd3, 8'd2);
        rd(7'd3, 8'h33, 8'h33);

        // Same-cycle swap and read uses the new bank; rd_data then holds
        wr(7'd7, 8'h77);
        done();
        ia.rd_swap = 1'b1; rd(7'd7, 8'h77, 8'h77);
        chk_stat("swap+read", 1'b0, 1'b0, 16'd4, 8'd2);
        repeat (3) tick();
        check("hold a.rd_data", ia.rd_data, 8'h77);
        check("hold b.rd_data", ib.rd_data, 8'h77);

        // Asynchronous reset mid-write and mid-read
        ia.wr_en = 1'b1; ia.wr_addr = 7'd9; ia.wr_data = 8'h99;
        ia.rd_en = 1'b1; ia.rd_addr = 7'd7;
        qa.push_back(8'h80); qb.push_back(8'h80);
        #2 reset = 1'b0;
        #1;
        check("async a.rd_data", ia.rd_data, 8'h80);
        check("async b.rd_data", ib.rd_data, 8'h80);
        chk_stat("async reset", 1'b0, 1'b0, 16'd0, 8'd0);
        tick();
        reset = 1'b1;

        // First frame after reset needs done and swap
        wr(7'd5, 8'h55);
        swap();
        chk_pulse("post-reset underrun", 1'b0, 1'b1, 1'b0);
        rd(7'd5, 8'h80, 8'h80);
        done();
        swap();
        chk_stat("post-reset swap", 1'b1, 1'b0, 16'd1, 8'd1);
        rd(7'd5, 8'h55, 8'h55);

        // Clean reset, then frame counter wrap and error counter saturation
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ia.wr_done = 1'b1; ia.rd_swap = 1'b1;
        repeat (65535) @(negedge clk);
        check("a.frame_cnt ffff", ia.frame_cnt, 16'hFFFF);
        @(negedge clk);
        check("a.frame_cnt wrap", ia.frame_cnt, 16'h0000);
        check("b.frame_cnt wrap", ib.frame_cnt, 16'h0000);
        check("a.rd_bank wrap", ia.rd_bank, 1'b0);
        ia.wr_done = 1'b0;
        repeat (254) @(negedge clk);
        check("a.err_cnt fe", ia.err_cnt, 8'hFE);
        repeat (46) @(negedge clk);
        ia.rd_swap = 1'b0;
        chk_stat("saturate", 1'b0, 1'b0, 16'd0, 8'hFF);
        tick();
        check("a.err_cnt hold", ia.err_cnt, 8'hFF);

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
